// File: rtl/sw_fifo_pkg.sv
// Shared constants and helpers for the Smith-Waterman score FIFO arbiter.
// Provides the default geometry, the depth derivation and the occupancy-count width.
package sw_fifo_pkg;

  localparam int unsigned DEF_N_REQ        = 4;
  localparam int unsigned DEF_ADDR_WIDTH   = 4;
  localparam int unsigned DEF_DATA_WIDTH   = 16;
  localparam int unsigned DEF_DEPTH        = 1 << DEF_ADDR_WIDTH;
  localparam int unsigned DEF_AFULL_THRESH = (DEF_DEPTH * 3) / 4;

  // Number of FIFO entries addressed by aw address bits.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 1 << aw;
  endfunction

  // Occupancy counter must hold 0..DEPTH inclusive, hence one extra bit.
  function automatic int unsigned count_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/sw_fifo_arbiter_if.sv
// Bus bundle between the writer PEs / consumer / score RAM and the FIFO arbiter.
// master: PEs, consumer and RAM side (drives req, req_data, rd_en, err_clr).
// slave:  the arbiter (drives grant, RAM ports, status and error flags).
interface sw_fifo_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
);

  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            grant;
  logic                        rd_en;
  logic                        rd_valid;
  logic                        mem_we;
  logic [ADDR_WIDTH-1:0]       mem_waddr;
  logic [DATA_WIDTH-1:0]       mem_wdata;
  logic [ADDR_WIDTH-1:0]       mem_raddr;
  logic [ADDR_WIDTH:0]         count;
  logic                        full;
  logic                        empty;
  logic                        almost_full;
  logic                        err_clr;
  logic                        overflow_err;
  logic                        underflow_err;

  modport master (
    output req, req_data, rd_en, err_clr,
    input  grant, rd_valid, mem_we, mem_waddr, mem_wdata, mem_raddr,
           count, full, empty, almost_full, overflow_err, underflow_err
  );

  modport slave (
    input  req, req_data, rd_en, err_clr,
    output grant, rd_valid, mem_we, mem_waddr, mem_wdata, mem_raddr,
           count, full, empty, almost_full, overflow_err, underflow_err
  );

endinterface

// File: rtl/sw_fifo_ptr.sv
// Write/read pointer registers for the score FIFO.
// Ports: clk, reset_n (async, active-low), inc_w / inc_r advance the
// respective pointer by one at the clock edge; w_ptr / r_ptr are the
// current addresses and wrap naturally modulo 2**ADDR_WIDTH.
module sw_fifo_ptr #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inc_w,
  input  logic                  inc_r,
  output logic [ADDR_WIDTH-1:0] w_ptr,
  output logic [ADDR_WIDTH-1:0] r_ptr
);

  // Pointer registers; power-of-two depth makes the wrap free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (inc_w) w_ptr <= w_ptr + ADDR_WIDTH'(1);
      if (inc_r) r_ptr <= r_ptr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sw_fifo_arbiter.sv
// Shares one score FIFO between N_REQ Smith-Waterman PEs and one consumer.
// Ports: clk, reset_n (async, active-low), bus (sw_fifo_arbiter_if.slave):
//   req/req_data/grant  round-robin arbitrated push side (grant combinational)
//   rd_en/rd_valid      pop side, read data on RAM output one cycle after pop
//   mem_*               external sync RAM write/read ports
//   count/full/empty/almost_full  status decoded from the registered count
//   err_clr/overflow_err/underflow_err  sticky misuse flags
module sw_fifo_arbiter
  import sw_fifo_pkg::*;
#(
  parameter int unsigned N_REQ        = DEF_N_REQ,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned AFULL_THRESH = DEF_AFULL_THRESH
) (
  input logic              clk,
  input logic              reset_n,
  sw_fifo_arbiter_if.slave bus
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned CW    = count_width(ADDR_WIDTH);
  localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [CW-1:0]         count_q;
  logic [IW-1:0]         rr_ptr;
  logic                  rd_valid_q;
  logic                  ovf_q;
  logic                  udf_q;
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;

  logic                  full_c;
  logic                  empty_c;
  logic                  found_c;
  logic [IW-1:0]         gnt_idx_c;
  logic [N_REQ-1:0]      grant_c;
  logic                  push_c;
  logic                  pop_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] pe_data [N_REQ];

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  // Split the flat request data bus into one word per PE.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign pe_data[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting at rr_ptr; nothing is granted while full,
  // even if a pop is happening in the same cycle.
  always_comb begin
    int unsigned cand;
    found_c   = 1'b0;
    gnt_idx_c = '0;
    grant_c   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found_c && bus.req[IW'(cand)]) begin
        found_c   = 1'b1;
        gnt_idx_c = IW'(cand);
      end
    end
    if (found_c && !full_c) grant_c[gnt_idx_c] = 1'b1;
  end

  assign push_c  = |grant_c;
  // A pop at empty is ignored even when a push lands in the same cycle.
  assign pop_c   = bus.rd_en & ~empty_c;
  assign wdata_c = pe_data[gnt_idx_c];

  sw_fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_w   (push_c),
    .inc_r   (pop_c),
    .w_ptr   (w_ptr),
    .r_ptr   (r_ptr)
  );

  // Occupancy, arbitration pointer, read-valid pipe and sticky errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      rr_ptr     <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      unique case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (push_c) begin
        rr_ptr <= (gnt_idx_c == IW'(N_REQ - 1)) ? '0 : gnt_idx_c + IW'(1);
      end

      rd_valid_q <= pop_c;

      // A new error in the same cycle takes priority over the clear.
      if (|bus.req && full_c) ovf_q <= 1'b1;
      else if (bus.err_clr)   ovf_q <= 1'b0;

      if (bus.rd_en && empty_c) udf_q <= 1'b1;
      else if (bus.err_clr)     udf_q <= 1'b0;
    end
  end

  assign bus.grant         = grant_c;
  assign bus.mem_we        = push_c;
  assign bus.mem_waddr     = w_ptr;
  assign bus.mem_wdata     = wdata_c;
  assign bus.mem_raddr     = r_ptr;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.count         = count_q;
  assign bus.full          = full_c;
  assign bus.empty         = empty_c;
  assign bus.almost_full   = (count_q >= CW'(AFULL_THRESH));
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;

endmodule

// File: tb/tb_sw_fifo_arbiter.sv
// Self-checking bench for sw_fifo_arbiter: directed scenarios plus random
// traffic, checked against a queue-based FIFO model and a sync-RAM model.
module tb_sw_fifo_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 12;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sw_fifo_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sw_fifo_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(AF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // External score RAM: synchronous write, synchronous read.
  logic [DW-1:0] ram [D];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
    ram_q <= ram[bus.mem_raddr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] pe_data [N];
  logic [DW-1:0] q [$];
  int            wa, ra, rr;
  bit            m_ovf, m_udf, m_rdv;
  logic [DW-1:0] m_rdata;
  logic [N-1:0]  e_grant;
  int            e_gi;
  logic [DW-1:0] e_wdata;

  function automatic void model_reset();
    q.delete();
    wa = 0; ra = 0; rr = 0;
    m_ovf = 1'b0; m_udf = 1'b0; m_rdv = 1'b0;
    m_rdata = '0;
  endfunction

  // Expected grant: first requester at or after rr (wrapping), none when full.
  function automatic void predict();
    e_grant = '0;
    e_gi    = 0;
    if (q.size() < D) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr + k) % N;
        if (bus.req[2'(c)] && e_grant == '0) begin
          e_grant[2'(c)] = 1'b1;
          e_gi = c;
        end
      end
    end
    e_wdata = pe_data[2'(e_gi)];
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic rd, input logic clr);
    bus.req      = r;
    bus.rd_en    = rd;
    bus.err_clr  = clr;
    bus.req_data = {pe_data[3], pe_data[2], pe_data[1], pe_data[0]};
    #1;
  endtask

  // Advance model by one clock using the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit is_full, is_empty, push, pop;
    predict();
    is_full  = (q.size() == D);
    is_empty = (q.size() == 0);
    push     = (e_grant != '0);
    pop      = bus.rd_en && !is_empty;
    if (bus.rd_en && is_empty)       m_udf = 1'b1;
    else if (bus.err_clr)            m_udf = 1'b0;
    if ((bus.req != '0) && is_full)  m_ovf = 1'b1;
    else if (bus.err_clr)            m_ovf = 1'b0;
    m_rdv = pop;
    if (pop) begin
      m_rdata = q.pop_front();
      ra = (ra + 1) % D;
    end
    if (push) begin
      q.push_back(e_wdata);
      wa = (wa + 1) % D;
      rr = (e_gi + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0, 1'b0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) pe_data[i] = '0;
    drive('0, 1'b0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.mem_we); end
    checks++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
      errors++; $display("FAIL reset_errs got %b%b want 00", bus.overflow_err, bus.underflow_err); end
    checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags got full=%b af=%b rdv=%b want 0 0 0", bus.full, bus.almost_full, bus.rd_valid); end
    checks++; if (bus.mem_waddr !== 4'd0 || bus.mem_raddr !== 4'd0) begin
      errors++; $display("FAIL reset_addr got w=%0d r=%0d want 0 0", bus.mem_waddr, bus.mem_raddr); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    pe_data[0] = 16'h0011; pe_data[1] = 16'h0022;
    pe_data[2] = 16'h0033; pe_data[3] = 16'h0044;
    drive(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_g = '0;
      exp_g[2'(k)] = 1'b1;
      checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, bus.grant, exp_g); end
      checks++; if (bus.mem_waddr !== 4'(k) || bus.mem_wdata !== pe_data[2'(k)]) begin
        errors++; $display("FAIL rr_write%0d got a=%0d d=%h want a=%0d d=%h", k, bus.mem_waddr, bus.mem_wdata, k, pe_data[2'(k)]); end
      tick();
    end
    drive('0, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd4) begin errors++; $display("FAIL rr_count got %0d want 4", bus.count); end
  endtask

  task automatic test_full_overflow();
    int guard = 0;
    while (q.size() < D && guard < 40) begin
      pe_data[2] = 16'($urandom);
      drive(4'b0100, 1'b0, 1'b0);
      tick();
      guard++;
    end
    checks++; if (guard >= 40) begin errors++; $display("FAIL fill_timeout got %0d entries want %0d", q.size(), D); end
    drive(4'b0100, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
      errors++; $display("FAIL full_state got count=%0d full=%b want 16 1", bus.count, bus.full); end
    checks++; if (bus.grant !== 4'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL full_grant got %b we=%b want 0000 0", bus.grant, bus.mem_we); end
    tick();
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", bus.overflow_err); end
    drive(4'b0100, 1'b1, 1'b0);
    checks++; if (bus.grant !== 4'b0) begin errors++; $display("FAIL full_pop_grant got %b want 0000", bus.grant); end
    tick();
    drive(4'b0100, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd15 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL full_pop got count=%0d rdv=%b want 15 1", bus.count, bus.rd_valid); end
    checks++; if (ram_q !== m_rdata) begin errors++; $display("FAIL full_pop_data got %h want %h", ram_q, m_rdata); end
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL refill_grant got %b want 0100", bus.grant); end
    tick();
    drive('0, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL refill_count got %0d want 16", bus.count); end
  endtask

  task automatic test_underflow();
    do_reset();
    pe_data[1] = 16'hBEEF;
    drive(4'b0010, 1'b1, 1'b0);
    checks++; if (bus.grant !== 4'b0010 || bus.mem_waddr !== 4'd0 || bus.mem_we !== 1'b1) begin
      errors++; $display("FAIL udf_push got g=%b a=%0d we=%b want 0010 0 1", bus.grant, bus.mem_waddr, bus.mem_we); end
    tick();
    drive('0, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd1 || bus.rd_valid !== 1'b0 || bus.underflow_err !== 1'b1) begin
      errors++; $display("FAIL udf_state got c=%0d rdv=%b udf=%b want 1 0 1", bus.count, bus.rd_valid, bus.underflow_err); end
    drive('0, 1'b0, 1'b1);
    tick();
    checks++; if (bus.underflow_err !== 1'b0) begin errors++; $display("FAIL udf_clear got %b want 0", bus.underflow_err); end
    drive('0, 1'b1, 1'b0);
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || ram_q !== 16'hBEEF) begin
      errors++; $display("FAIL udf_readback got rdv=%b d=%h want 1 beef", bus.rd_valid, ram_q); end
    drive('0, 1'b1, 1'b1);
    tick();
    checks++; if (bus.underflow_err !== 1'b1) begin errors++; $display("FAIL udf_set_beats_clear got %b want 1", bus.underflow_err); end
    drive('0, 1'b0, 1'b1);
    tick();
    checks++; if (bus.underflow_err !== 1'b0) begin errors++; $display("FAIL udf_clear2 got %b want 0", bus.underflow_err); end
    drive('0, 1'b0, 1'b0);
  endtask

  // Compares every DUT output against the model for n cycles of traffic.
  // mode 0: phased fill / interleave / drain; mode 1: fully random.
  task automatic run_traffic(input int n, input int mode);
    logic [N-1:0] r;
    logic rd, clr;
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int i = 0; i < N; i++) pe_data[i] = 16'($urandom);
      if (mode == 0) begin
        r   = (cyc < 20) ? 4'($urandom_range(1, 15)) : 4'b0;
        rd  = (cyc >= 13);
        clr = 1'b0;
      end else begin
        r   = 4'($urandom);
        rd  = ($urandom_range(0, 99) < 45);
        clr = ($urandom_range(0, 99) < 10);
      end
      drive(r, rd, clr);
      predict();
      checks++; if (bus.grant !== e_grant || bus.mem_we !== (e_grant != '0)) begin
        errors++; $display("FAIL traffic_grant c%0d got %b we=%b want %b", cyc, bus.grant, bus.mem_we, e_grant); end
      if (e_grant != '0) begin
        checks++; if (bus.mem_waddr !== 4'(wa) || bus.mem_wdata !== e_wdata) begin
          errors++; $display("FAIL traffic_write c%0d got a=%0d d=%h want a=%0d d=%h", cyc, bus.mem_waddr, bus.mem_wdata, wa, e_wdata); end
      end
      checks++; if (bus.mem_raddr !== 4'(ra)) begin
        errors++; $display("FAIL traffic_raddr c%0d got %0d want %0d", cyc, bus.mem_raddr, ra); end
      checks++; if (bus.count !== 5'(q.size()) || bus.almost_full !== (q.size() >= AF) ||
                    bus.full !== (q.size() == D) || bus.empty !== (q.size() == 0)) begin
        errors++; $display("FAIL traffic_status c%0d got c=%0d af=%b f=%b e=%b want c=%0d", cyc,
                           bus.count, bus.almost_full, bus.full, bus.empty, q.size()); end
      checks++; if (bus.rd_valid !== m_rdv || bus.overflow_err !== m_ovf || bus.underflow_err !== m_udf) begin
        errors++; $display("FAIL traffic_flags c%0d got rdv=%b ovf=%b udf=%b want %b %b %b", cyc,
                           bus.rd_valid, bus.overflow_err, bus.underflow_err, m_rdv, m_ovf, m_udf); end
      if (m_rdv) begin
        checks++; if (ram_q !== m_rdata) begin
          errors++; $display("FAIL traffic_rdata c%0d got %h want %h", cyc, ram_q, m_rdata); end
      end
      tick();
    end
    drive('0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_interleave();
    do_reset();
    run_traffic(33, 0);
    checks++; if (bus.empty !== 1'b1 || bus.mem_waddr !== 4'd4 || bus.mem_raddr !== 4'd4) begin
      errors++; $display("FAIL wrap_end got e=%b w=%0d r=%0d want 1 4 4", bus.empty, bus.mem_waddr, bus.mem_raddr); end
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(400, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    pe_data[3] = 16'h7777;
    drive(4'b1000, 1'b0, 1'b0);
    repeat (8) tick();
    drive('0, 1'b1, 1'b0);
    tick();
    checks++; if (bus.count !== 5'd7 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got c=%0d rdv=%b want 7 1", bus.count, bus.rd_valid); end
    reset_n = 1'b0;
    #2;
    checks++; if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL mid_async got c=%0d rdv=%b e=%b want 0 0 1", bus.count, bus.rd_valid, bus.empty); end
    drive('0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(4'b1000, 1'b0, 1'b0);
    checks++; if (bus.grant !== 4'b1000 || bus.mem_waddr !== 4'd0) begin
      errors++; $display("FAIL mid_first_push got g=%b a=%0d want 1000 0", bus.grant, bus.mem_waddr); end
    tick();
    drive('0, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL mid_count got %0d want 1", bus.count); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_full_overflow();
    test_underflow();
    test_wrap_interleave();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_fifo_arbiter.md
Name: sw_fifo_arbiter

Overview:
- Shares one score FIFO (external single-port-write / single-port-read sync RAM, depth 2**ADDR_WIDTH) between N_REQ Smith-Waterman processing elements (writers) and one traceback/max-search consumer (reader).
- Round-robin arbitrates writer requests and tracks occupancy, full, empty and almost-full.
- Drives the RAM write/read ports and flags overflow/underflow attempts.
- Pointer sequencing lives in a sub-module; this block decides when the pointers advance.

Parameters:
- N_REQ, 4, number of writer PEs (≥2).
- ADDR_WIDTH, 4, FIFO address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, score word width.
- AFULL_THRESH, 12, almost_full asserts when count ≥ this value (1..DEPTH).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-PE push request, level; held until granted
- req_data  in  N_REQ*DATA_WIDTH  PE i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- grant  out  N_REQ  one-hot combinational grant; push of PE i occurs at the edge where req[i]&grant[i]
- rd_en  in  1  consumer pop request
- rd_valid  out  1  registered; RAM read data valid this cycle
- mem_we  out  1  RAM write enable (combinational)
- mem_waddr  out  ADDR_WIDTH  RAM write address
- mem_wdata  out  DATA_WIDTH  RAM write data (granted PE's word)
- mem_raddr  out  ADDR_WIDTH  RAM read address
- count  out  ADDR_WIDTH+1  occupancy 0..DEPTH
- full, empty, almost_full  out  1 each  status, decoded from registered count
- err_clr  in  1  clears sticky error flags
- overflow_err, underflow_err  out  1 each  sticky error flags

Behaviour:
- Reset (reset_n=0, async): w_ptr=0, r_ptr=0, count=0, rr_ptr=0, rd_valid=0, both error flags=0. Hence empty=1, full=0, almost_full=0, grant=0, mem_we=0, mem_waddr=0, mem_raddr=0.
- A reset mid-operation discards the contents; in-flight rd_valid drops immediately.
- Arbitration, combinational:
  - Search req starting at index rr_ptr, ascending with wrap; the first asserted index i gets grant[i]=1.
  - grant is all-zero when full=1; the pop in the same cycle does not free a slot for that cycle.
  - After a push by PE i: rr_ptr <= (i+1) mod N_REQ. With no push, rr_ptr holds.
- Push: accept = |grant.
  - mem_we = accept, mem_waddr = w_ptr, mem_wdata = req_data slice of the granted PE.
  - At the edge, w_ptr <= w_ptr+1, wrapping DEPTH-1 -> 0.
- Pop: pop = rd_en & ~empty.
  - mem_raddr = r_ptr at all times.
  - At the edge, r_ptr <= r_ptr+1 with wrap; rd_valid <= pop, giving 1-cycle read latency and data on the RAM output the cycle after pop.
- Count:
  - push only: +1; pop only: −1; both or neither: unchanged.
  - full = (count==DEPTH); empty = (count==0).
  - Pointers are equal both at full and at empty; count disambiguates.
- Simultaneous push and pop:
  - At empty: push accepted, pop ignored, count goes 0->1, underflow_err set.
  - At full: pop accepted, no grant, count goes DEPTH->DEPTH−1.
  - Otherwise both proceed and count is unchanged.
- Errors:
  - underflow_err <= 1 when rd_en & empty.
  - overflow_err <= 1 when any req is asserted while full.
  - Flags are sticky until err_clr=1, which clears them at the edge; a same-cycle new error wins over the clear.
- Pointer and count arithmetic is unsigned and modulo DEPTH for the pointers. No pointer is ever reset to a non-zero value.

Decomposition:
- Shared package sw_fifo_pkg holds:
  - localparam DEPTH derivation;
  - the count width function (ADDR_WIDTH+1);
  - default constants ADDR_WIDTH=4, DATA_WIDTH=16.
- One sub-module, sw_fifo_ptr: wraps the w_ptr/r_ptr registers with inc_w/inc_r inputs, ADDR_WIDTH-wide outputs, async active-low reset to 0.
- Arbiter, count and error logic stay in the top.

Test Plan:
- Reset release, then idle 5 cycles -> empty=1, count=0, grant=0, mem_we=0, both errors 0.
- req=4'b1111 held 4 cycles with data 0x0011/0x0022/0x0033/0x0044 -> grant order PE0,1,2,3; mem_waddr 0,1,2,3; count=4.
- Fill to 16 (ADDR_WIDTH=4), keep req[2]=1 -> grant=0, full=1, overflow_err=1. Then one rd_en -> count=15, next cycle grant[2]=1.
- Empty FIFO, rd_en=1 and req[1]=1 same cycle -> push to addr 0, count=1, rd_valid=0 next cycle, underflow_err=1. err_clr -> flag 0.
- 20 pushes interleaved with 20 pops -> mem_waddr and mem_raddr wrap 15->0; read data order equals push order; almost_full toggles at count 12.
- Assert reset_n=0 mid-stream at count=7 -> count=0, rd_valid=0 asynchronously. After release, the first push goes to addr 0.
